// File: rtl/spi_pkg.sv
// Shared constants for the SPI transmit FIFO launcher.
// Launch FSM state encodings are kept as plain 2-bit constants for
// compatibility with existing users of these values.
package spi_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

endpackage

// File: rtl/sync_fifo_mem.sv
// Circular FIFO storage with read/write pointers and an occupancy counter.
// Push qualification lives here: a push while full succeeds only when a pop
// happens in the same cycle; otherwise it is dropped and flagged.
module sync_fifo_mem #(
  parameter int unsigned bus_width  = 8,
  parameter int unsigned depth      = 8,
  parameter int unsigned addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [bus_width-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [bus_width-1:0]  rd_data,
  output logic [addr_width:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow
);

  logic [bus_width-1:0]  mem_q [depth];
  logic [addr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [addr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [addr_width:0]   count_q, count_d;
  logic                  push_ok;

  // Status flags and push qualification derived from the registered count.
  always_comb begin
    full     = (count_q == (addr_width+1)'(depth));
    empty    = (count_q == '0);
    push_ok  = wr_en && (!full || rd_en);
    overflow = !rst && wr_en && full && !rd_en;
    count    = count_q;
    rd_data  = mem_q[rd_ptr_q];
  end

  // Next pointer and occupancy values; pointers wrap naturally at depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + addr_width'(1);
    if (rd_en)   rd_ptr_d = rd_ptr_q + addr_width'(1);
    case ({push_ok, rd_en})
      2'b10:   count_d = count_q + (addr_width+1)'(1);
      2'b01:   count_d = count_q - (addr_width+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since the count gates reads.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO feeding an SPI master through a four-state launch FSM.
// Optional receive capture is enabled with macro SPI_TX_FIFO_RX_CAPTURE_EN.
module spi_tx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned bus_width  = 8,
  parameter int unsigned depth      = 8,
  parameter int unsigned addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [bus_width-1:0]  i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [addr_width:0]   o_count,
  output logic                  o_overflow,
  input  logic                  i_tx_rdy,
  output logic [bus_width-1:0]  o_tx_byte,
  output logic                  o_tx_dv,
`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
  output logic                  o_busy,
  input  logic [bus_width-1:0]  i_rx_byte,
  output logic [bus_width-1:0]  o_rx_byte,
  output logic                  o_rx_valid
`else
  output logic                  o_busy
`endif
);

  logic [1:0]           state_q, state_d;
  logic [bus_width-1:0] tx_byte_q, tx_byte_d;
  logic [bus_width-1:0] head_data;
  logic                 pop;

  sync_fifo_mem #(
    .bus_width  (bus_width),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (i_wr_en),
    .wr_data  (i_wr_data),
    .rd_en    (pop),
    .rd_data  (head_data),
    .count    (o_count),
    .full     (o_full),
    .empty    (o_empty),
    .overflow (o_overflow)
  );

  // Launch FSM next state; the head entry is popped on the IDLE->LAUNCH edge.
  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!o_empty && i_tx_rdy) begin
          pop       = 1'b1;
          tx_byte_d = head_data;
          state_d   = LAUNCH;
        end
      end
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: if (!i_tx_rdy) state_d = WAIT_DONE;
      WAIT_DONE: if (i_tx_rdy)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM state and held transmit byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_byte_q <= '0;
    end else begin
      state_q   <= state_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  // Strobe and busy are decoded straight from state, so reset clears them.
  always_comb begin
    o_tx_dv   = (state_q == LAUNCH);
    o_busy    = (state_q != IDLE);
    o_tx_byte = tx_byte_q;
  end

`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
  logic [bus_width-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_valid_q, rx_valid_d;

  // Capture the received byte as the transfer completes.
  always_comb begin
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    if (state_q == WAIT_DONE && i_tx_rdy) begin
      rx_byte_d  = i_rx_byte;
      rx_valid_d = 1'b1;
    end
  end

  // Receive capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign o_rx_byte  = rx_byte_q;
  assign o_rx_valid = rx_valid_q;
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Directed bench for spi_tx_fifo: a vector table for push/launch/overflow
// behaviour, then hand-written sequences for drain order, full push+pop,
// mid-transfer reset and (when enabled) receive capture.
module tb_spi_tx_fifo;

  logic       clk;
  logic       rst;
  logic       i_wr_en;
  logic [7:0] i_wr_data;
  logic       o_full, o_empty, o_overflow;
  logic [3:0] o_count;
  logic       i_tx_rdy;
  logic [7:0] o_tx_byte;
  logic       o_tx_dv, o_busy;
`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
  logic [7:0] i_rx_byte, o_rx_byte;
  logic       o_rx_valid;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  spi_tx_fifo #(.bus_width(8), .depth(8), .addr_width(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .i_tx_rdy   (i_tx_rdy),
    .o_tx_byte  (o_tx_byte),
    .o_tx_dv    (o_tx_dv),
`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
    .o_busy     (o_busy),
    .i_rx_byte  (i_rx_byte),
    .o_rx_byte  (o_rx_byte),
    .o_rx_valid (o_rx_valid)
`else
    .o_busy     (o_busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_rdy;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       dv;
    logic       busy;
    logic [7:0] tx_byte;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [7:0] exp_bytes[$];
    int unsigned n_dv;
    logic prev_dv;

    rst = 1'b1; i_wr_en = 1'b0; i_wr_data = '0; i_tx_rdy = 1'b0;
`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
    i_rx_byte = '0;
`endif

    // rst wr data rdy | count full empty ovf dv busy byte
    vecs[0]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 1'b1, 8'h01, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};
    for (int unsigned k = 2; k <= 8; k++)
      vecs[k+4] = '{1'b0, 1'b1, 8'(k), 1'b0, 4'(k-1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
    vecs[13] = '{1'b0, 1'b1, 8'h09, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};

    repeat (2) @(posedge clk);

    // Table: drive at negedge, check just after (state from earlier edges).
    for (int unsigned i = 0; i < 15; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; i_wr_en = vecs[i].wr_en;
      i_wr_data = vecs[i].wr_data; i_tx_rdy = vecs[i].tx_rdy;
      #1;
      check($sformatf("row%0d count", i),   o_count,    vecs[i].count);
      check($sformatf("row%0d full", i),    o_full,     vecs[i].full);
      check($sformatf("row%0d empty", i),   o_empty,    vecs[i].empty);
      check($sformatf("row%0d overflow", i), o_overflow, vecs[i].ovf);
      check($sformatf("row%0d tx_dv", i),   o_tx_dv,    vecs[i].dv);
      check($sformatf("row%0d busy", i),    o_busy,     vecs[i].busy);
      check($sformatf("row%0d tx_byte", i), o_tx_byte,  vecs[i].tx_byte);
    end

    // Push and pop together while full: push of 0x10 must be accepted.
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h10; i_tx_rdy = 1'b1;
    #1;
    check("full push+pop overflow", o_overflow, 1'b0);
    check("full push+pop full", o_full, 1'b1);
    @(negedge clk);
    i_wr_en = 1'b0;
    #1;
    check("full push+pop count", o_count, 4'd8);

    // Drain with one-cycle-low handshakes; order must match push order.
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10};
    n_dv = 0;
    prev_dv = 1'b0;
    for (int unsigned c = 0; c < 60; c++) begin
      i_tx_rdy = prev_dv ? 1'b0 : 1'b1;
      if (o_tx_dv) begin
        if (n_dv < 9) check($sformatf("drain byte%0d", n_dv), o_tx_byte, exp_bytes[n_dv]);
        else check("drain extra tx_dv", n_dv, 9);
        n_dv++;
      end
      prev_dv = o_tx_dv;
      @(negedge clk); #1;
    end
    check("drain tx_dv count", n_dv, 9);
    check("drain count", o_count, 4'd0);
    check("drain empty", o_empty, 1'b1);

    // Reset while in WAIT_DONE with three entries still queued.
    i_tx_rdy = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      @(negedge clk);
      i_wr_en = 1'b1; i_wr_data = 8'h21 + 8'(k);
    end
    @(negedge clk);
    i_wr_en = 1'b0; i_tx_rdy = 1'b1;
    @(negedge clk);
    i_tx_rdy = 1'b0;
    #1;
    check("rst seq launch dv", o_tx_dv, 1'b1);
    check("rst seq launch byte", o_tx_byte, 8'h21);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst seq busy before", o_busy, 1'b1);
    check("rst seq count before", o_count, 4'd3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst seq count", o_count, 4'd0);
    check("rst seq empty", o_empty, 1'b1);
    check("rst seq busy", o_busy, 1'b0);
    check("rst seq tx_byte", o_tx_byte, 8'h00);
    rst = 1'b0; i_tx_rdy = 1'b1;
    n_dv = 0;
    for (int unsigned c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (o_tx_dv) n_dv++;
`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
      check($sformatf("rst seq rx_valid c%0d", c), o_rx_valid, 1'b0);
`endif
    end
    check("rst seq tx_dv after", n_dv, 0);

`ifdef SPI_TX_FIFO_RX_CAPTURE_EN
    // Receive capture on the WAIT_DONE -> IDLE edge.
    check("rx reset byte", o_rx_byte, 8'h00);
    @(negedge clk);
    i_wr_en = 1'b1; i_wr_data = 8'h77; i_tx_rdy = 1'b1;
    @(negedge clk);
    i_wr_en = 1'b0;
    @(negedge clk);
    i_tx_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_tx_rdy = 1'b1; i_rx_byte = 8'h3C;
    #1;
    check("rx valid before", o_rx_valid, 1'b0);
    @(negedge clk);
    i_rx_byte = 8'h00;
    #1;
    check("rx valid pulse", o_rx_valid, 1'b1);
    check("rx byte", o_rx_byte, 8'h3C);
    @(negedge clk);
    #1;
    check("rx valid after", o_rx_valid, 1'b0);
    check("rx byte held", o_rx_byte, 8'h3C);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_fifo.md
SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

Interface
REQ-001 Parameters SHALL be: bus_width, default 8, byte width; depth, default 8, FIFO entries (power of 2); addr_width, default 3, log2(depth).
REQ-002 Ports SHALL be:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- i_wr_en  in  1  push request
- i_wr_data  in  bus_width  byte to push
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_count  out  addr_width+1  entries held
- o_overflow  out  1  one-cycle pulse, push dropped
- i_tx_rdy  in  1  downstream SPI master ready
- o_tx_byte  out  bus_width  byte to SPI master
- o_tx_dv  out  1  one-cycle launch strobe to SPI master
- o_busy  out  1  high in any state other than IDLE
- i_rx_byte  in  bus_width  byte received by SPI master (RX_CAPTURE_EN only)
- o_rx_byte  out  bus_width  captured receive byte (RX_CAPTURE_EN only)
- o_rx_valid  out  1  one-cycle pulse, o_rx_byte updated (RX_CAPTURE_EN only)

Function
REQ-003 The FIFO SHALL be circular, with addr_width-bit read and write pointers that wrap depth-1 -> 0.
REQ-004 A push with i_wr_en=1 and o_full=0 SHALL store i_wr_data and increment o_count.
REQ-005 A push with o_full=1 and no pop in the same cycle SHALL be dropped, with o_overflow high for that one cycle; no FIFO state SHALL change.
REQ-006 A push and a pop in the same cycle SHALL both complete, leaving o_count unchanged; this SHALL hold when full and when count=1.
REQ-007 o_full SHALL equal (o_count==depth) and o_empty SHALL equal (o_count==0); both SHALL be registered-consistent with o_count.
REQ-008 The FSM SHALL have exactly four states: IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-009 IDLE -> LAUNCH SHALL occur when o_empty=0 and i_tx_rdy=1; at that edge the head entry SHALL be popped into o_tx_byte.
REQ-010 In LAUNCH, o_tx_dv SHALL be 1 for exactly one cycle and the next state SHALL be WAIT_BUSY.
REQ-011 WAIT_BUSY -> WAIT_DONE SHALL occur when i_tx_rdy=0.
REQ-012 WAIT_DONE -> IDLE SHALL occur when i_tx_rdy=1.
REQ-013 o_tx_byte SHALL hold its value from the pop until the next pop.
REQ-014 Latency: a push at edge N into an empty FIFO, with IDLE state and i_tx_rdy=1, SHALL produce o_tx_dv=1 in the cycle after edge N+1; no fall-through path SHALL exist.
REQ-015 Exactly one o_tx_dv pulse SHALL be issued per popped byte; bytes SHALL leave in push order.

Reset
REQ-016 While rst=1 at a clock edge, the block SHALL set:
- state IDLE, pointers 0
- o_count 0, o_empty 1, o_full 0
- o_overflow 0, o_tx_dv 0, o_tx_byte 0, o_busy 0
- o_rx_byte 0, o_rx_valid 0
REQ-017 Reset asserted mid-transfer SHALL discard all FIFO contents and any in-flight byte; no o_tx_dv or o_rx_valid SHALL be issued for that byte.

Configuration
REQ-018 With macro SPI_TX_FIFO_RX_CAPTURE_EN defined, the WAIT_DONE -> IDLE edge SHALL latch i_rx_byte into o_rx_byte and pulse o_rx_valid for one cycle.
REQ-019 With SPI_TX_FIFO_RX_CAPTURE_EN undefined, ports i_rx_byte, o_rx_byte and o_rx_valid SHALL not exist and no capture logic SHALL be built.

Structure
REQ-020 The FSM state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT_BUSY=2'd2, WAIT_DONE=2'd3) SHALL live in the shared package spi_pkg.
REQ-021 Storage and pointers SHALL be a sub-module named sync_fifo_mem; the launch FSM SHALL stay in spi_tx_fifo.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset, then push 0xA5 with i_tx_rdy=1 -> o_tx_dv pulse one cycle after the push edge, o_tx_byte=0xA5, o_count back to 0.
- Hold i_tx_rdy=0, push 9 bytes 0x01..0x09 -> o_full=1 after 8 pushes, o_overflow pulse on the 9th, o_count=8.
- Drive i_tx_rdy with 1-cycle-low-then-high handshakes -> output order 0x01..0x08, exactly 8 o_tx_dv pulses, wrap-around exercised.
- Push and pop in the same cycle while full -> o_count stays 8, o_overflow=0.
- Assert rst while in WAIT_DONE with 3 entries queued -> o_count=0, state IDLE, no further o_tx_dv.
- RX_CAPTURE_EN defined, i_rx_byte=0x3C when i_tx_rdy returns high -> o_rx_byte=0x3C, o_rx_valid pulse for one cycle.
